rand_array_loader: RTL and testbench
====================================

Name: rand_array_loader

Overview:
- Consumer end of the on-board pseudo-random source: requests 4-bit random values over a valid/ready handshake and fills an N-entry bar array for the sorting visualiser.
- Filters each value against a legal range and, optionally, rejects duplicates so the array is a set of distinct bar heights.
- Sits between the LFSR source and the sort engine/display. Exposes the filled array flat, plus a per-entry write strobe for RAM-backed consumers.

Parameters:
- N, 6, number of array entries (2..16).
- W, 4, value width in bits.
- MIN_VAL, 1, smallest accepted value (inclusive).
- MAX_VAL, 15, largest accepted value (inclusive); must be < 2**W.
- UNIQUE, 1, 1 = reject values already written during the current fill.
- Elaboration error if MIN_VAL > MAX_VAL, or if UNIQUE=1 and (MAX_VAL-MIN_VAL+1) < N.
- Local: AW = max(1, ceil(log2(N))).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a fill; honoured only in IDLE
- rnd_valid  in  1  source has a value on rnd_data
- rnd_data  in  W  random value
- rnd_ready  out  1  loader accepts rnd_data this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the fill completes
- wr_en  out  1  one-cycle write strobe per accepted entry
- wr_addr  out  AW  index being written
- wr_data  out  W  value being written
- array_flat  out  N*W  entry i at bits [i*W +: W]
- reject_count  out  8  values rejected during the current fill; saturates at 255

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - All outputs 0: rnd_ready, busy, done, wr_en, wr_addr, wr_data, array_flat, reject_count.
  - Internal index, sample register and seen bitmap (2**W bits) cleared.
  - Reset overrides all other inputs and aborts a fill in progress; no partial done pulse.
- State machine, all outputs registered or decoded from state:
  - IDLE: start=1 clears array_flat, seen bitmap, index and reject_count, then moves to FETCH.
  - FETCH: rnd_ready=1. When rnd_valid && rnd_ready, capture rnd_data into the sample register and move to CHECK. With rnd_valid=0 the loader holds in FETCH indefinitely.
  - CHECK: rnd_ready=0. Sample is accepted if MIN_VAL <= sample <= MAX_VAL and (UNIQUE=0 or seen[sample]=0).
    - Accepted: move to WRITE.
    - Rejected: reject_count+1 (saturating), return to FETCH.
  - WRITE: for exactly one cycle wr_en=1, wr_addr=index, wr_data=sample. Same edge updates array_flat[index], sets seen[sample] and increments index. Move to DONE if index == N-1, else FETCH.
  - DONE: done=1 for one cycle, then IDLE. array_flat holds its contents until the next start or reset.
- busy=1 in FETCH, CHECK, WRITE and DONE.
- start is ignored outside IDLE.
- start and rst in the same cycle: reset wins.
- Timing:
  - Accepted value: 3 cycles (FETCH handshake, CHECK, WRITE).
  - Rejected value: 2 cycles.
  - With rnd_valid held high and no rejects, done is high in cycle 3N+1 after the start edge (19 for N=6).
- Arithmetic: range compare is unsigned at width W. reject_count is 8-bit unsigned and saturates. The index never exceeds N-1.
- wr_en=0 and done=0 in every state other than WRITE and DONE respectively.

Test Plan:
- Basic fill: reset, rnd_valid=1, source supplies 9,3,6,13,10,5, pulse start. Expected:
  - 6 wr_en pulses with addr 0..5 and matching data.
  - array_flat = {5,10,13,6,3,9} (entry 5 in MSBs).
  - reject_count=0; done exactly 19 cycles after the start edge; busy low afterwards.
- Range reject (MAX_VAL=9 build): supply 0,12,4,… Expected:
  - 0 and 12 are not written; entry 0 = 4.
  - reject_count=2; each reject adds 2 cycles (done at cycle 23 for N=6).
- Duplicate reject (UNIQUE=1): supply 3,3,7,… Expected: entry0=3, entry1=7, reject_count=1. With a UNIQUE=0 build, entry1=3 and reject_count=0.
- Backpressure: drop rnd_valid for 5 cycles mid-fill. Expected: loader holds in FETCH with rnd_ready=1, no wr_en, index unchanged; done is delayed by exactly 5 cycles.
- Control corners:
  - start pulsed while busy: ignored, array unchanged.
  - rst asserted after 3 entries are written: next cycle state=IDLE with all outputs 0 and no done pulse.
  - A fresh start then completes a full fill normally.
- LFSR end-to-end: connect the 4-bit x^4+x^3+1 LFSR (seed 1001) as the source, rnd_valid=1, N=6. Expected: N distinct nonzero values, reject_count=0, done asserted.

Source files
------------

// File: rtl/rand_array_loader.sv
// rtl/rand_array_loader.sv - fills an N-entry bar array from a valid/ready random source
// Values outside [MIN_VAL, MAX_VAL] (or repeats, when UNIQUE=1) are dropped and counted.
module rand_array_loader #(
  parameter int N       = 6,
  parameter int W       = 4,
  parameter int MIN_VAL = 1,
  parameter int MAX_VAL = 15,
  parameter int UNIQUE  = 1,
  localparam int AW     = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            rnd_valid,
  input  logic [W-1:0]    rnd_data,
  output logic            rnd_ready,
  output logic            busy,
  output logic            done,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [W-1:0]    wr_data,
  output logic [N*W-1:0]  array_flat,
  output logic [7:0]      reject_count
);

  if (MIN_VAL > MAX_VAL) begin : g_bad_range
    $error("rand_array_loader: MIN_VAL must not exceed MAX_VAL");
  end
  if (MAX_VAL >= (1 << W)) begin : g_bad_max
    $error("rand_array_loader: MAX_VAL must fit in W bits");
  end
  if (UNIQUE != 0 && (MAX_VAL - MIN_VAL + 1) < N) begin : g_bad_unique
    $error("rand_array_loader: legal range too small for N distinct values");
  end

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, WRITE, DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  state_t             state, state_nxt;
  logic [AW-1:0]      index;
  logic [W-1:0]       sample;
  logic [2**W-1:0]    seen;
  logic [N*W-1:0]     array_q;
  logic [7:0]         rej_q;
  logic               in_range;
  logic               accept;

  // Compared as integers so a full-range MAX_VAL does not reduce to a constant compare.
  assign in_range = (int'(sample) >= MIN_VAL) && (int'(sample) <= MAX_VAL);
  assign accept   = in_range && ((UNIQUE == 0) || !seen[sample]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      index   <= '0;
      sample  <= '0;
      seen    <= '0;
      array_q <= '0;
      rej_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            index   <= '0;
            seen    <= '0;
            array_q <= '0;
            rej_q   <= '0;
          end
        end
        FETCH: begin
          if (rnd_valid) sample <= rnd_data;
        end
        CHECK: begin
          if (!accept && rej_q != 8'hFF) rej_q <= rej_q + 8'd1;
        end
        WRITE: begin
          array_q[index*W +: W] <= sample;
          seen[sample]          <= 1'b1;
          if (index != LAST_IDX) index <= index + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (rnd_valid) state_nxt = CHECK;
      CHECK:   state_nxt = accept ? WRITE : FETCH;
      WRITE:   state_nxt = (index == LAST_IDX) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data are gated so the write port reads zero outside the strobe.
  assign rnd_ready    = (state == FETCH);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign wr_en        = (state == WRITE);
  assign wr_addr      = wr_en ? index : '0;
  assign wr_data      = wr_en ? sample : '0;
  assign array_flat   = array_q;
  assign reject_count = rej_q;

endmodule

// File: tb/tb_rand_array_loader.sv
// tb/tb_rand_array_loader.sv - scoreboard bench for rand_array_loader
// Instance 0: default build; instance 1: MAX_VAL=9, UNIQUE=0.
module tb_rand_array_loader;
  localparam int N  = 6;
  localparam int W  = 4;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            start [2];
  logic            rnd_valid [2];
  logic            rnd_ready [2];
  logic            busy [2];
  logic            done [2];
  logic            wr_en [2];
  logic [W-1:0]    rnd_data [2];
  logic [W-1:0]    wr_data [2];
  logic [AW-1:0]   wr_addr [2];
  logic [N*W-1:0]  array_flat [2];
  logic [7:0]      reject_count [2];

  rand_array_loader #(.N(N), .W(W), .MIN_VAL(1), .MAX_VAL(15), .UNIQUE(1)) d0 (
    .clk(clk), .rst(rst), .start(start[0]), .rnd_valid(rnd_valid[0]), .rnd_data(rnd_data[0]),
    .rnd_ready(rnd_ready[0]), .busy(busy[0]), .done(done[0]), .wr_en(wr_en[0]),
    .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .array_flat(array_flat[0]),
    .reject_count(reject_count[0]));

  rand_array_loader #(.N(N), .W(W), .MIN_VAL(1), .MAX_VAL(9), .UNIQUE(0)) d1 (
    .clk(clk), .rst(rst), .start(start[1]), .rnd_valid(rnd_valid[1]), .rnd_data(rnd_data[1]),
    .rnd_ready(rnd_ready[1]), .busy(busy[1]), .done(done[1]), .wr_en(wr_en[1]),
    .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .array_flat(array_flat[1]),
    .reject_count(reject_count[1]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Random source: a per-instance FIFO of values presented over valid/ready.
  logic [W-1:0] src_mem [2][256];
  int           src_wr [2];
  int           src_rd [2];
  logic         valid_en [2];
  logic         flush [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rnd_valid[i] = valid_en[i] && (src_rd[i] != src_wr[i]);
      rnd_data[i]  = rnd_valid[i] ? src_mem[i][src_rd[i][7:0]] : '0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (flush[i])                        src_rd[i] <= src_wr[i];
      else if (rnd_valid[i] && rnd_ready[i]) src_rd[i] <= src_rd[i] + 1;
    end
  end

  // Reference model and write scoreboard.
  int           exp_q[$];
  int           sb_exp;
  logic [W-1:0] exp_arr [2][N];
  int           m_cnt [2];
  int           m_rej [2];
  logic [15:0]  m_seen [2];
  int           m_max [2];
  int           m_uniq [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 64'(wr_data[i]), 64'hFFFF);
        end else begin
          sb_exp = exp_q.pop_front();
          check("wr_entry", 64'(i * 256 + int'(wr_addr[i]) * 16 + int'(wr_data[i])), 64'(sb_exp));
        end
      end
    end
  end

  task automatic begin_fill(input int id);
    m_cnt[id]  = 0;
    m_rej[id]  = 0;
    m_seen[id] = '0;
    for (int k = 0; k < N; k++) exp_arr[id][k] = '0;
    valid_en[id] = 1'b0;
    flush[id]    = 1'b1;
    @(posedge clk);
    #1 flush[id] = 1'b0;
  endtask

  task automatic supply(input int id, input int v);
    if (m_cnt[id] < N) begin
      src_mem[id][src_wr[id]] = W'(v);
      src_wr[id]++;
      if (v >= 1 && v <= m_max[id] && !(m_uniq[id] != 0 && m_seen[id][v])) begin
        exp_q.push_back(id * 256 + m_cnt[id] * 16 + v);
        exp_arr[id][m_cnt[id]] = W'(v);
        m_seen[id][v] = 1'b1;
        m_cnt[id]++;
      end else begin
        m_rej[id]++;
      end
    end
  endtask

  function automatic logic [N*W-1:0] model_flat(input int id);
    logic [N*W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = exp_arr[id][k];
    return r;
  endfunction

  task automatic run_fill(input int id, input int stall_at, input int busy_start_at, input string tag);
    int cyc;
    int exp_cyc;
    exp_cyc = 3 * N + 1 + 2 * m_rej[id] + ((stall_at > 0) ? 5 : 0);
    valid_en[id] = 1'b1;
    @(negedge clk) start[id] = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      start[id] = 1'b0;
      cyc++;
      if (stall_at > 0 && cyc > stall_at && cyc <= stall_at + 5) begin
        check({tag, "_stall_ready"}, 64'(rnd_ready[id]), 64'd1);
        check({tag, "_stall_wr_en"}, 64'(wr_en[id]), 64'd0);
      end
      if (stall_at > 0 && cyc == stall_at)     valid_en[id] = 1'b0;
      if (stall_at > 0 && cyc == stall_at + 6) valid_en[id] = 1'b1;
      if (busy_start_at > 0 && cyc == busy_start_at) start[id] = 1'b1;
      if (done[id] || cyc >= 200) break;
    end
    check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_reject_count"}, 64'(reject_count[id]), 64'(m_rej[id]));
    check({tag, "_array"}, 64'(array_flat[id]), 64'(model_flat(id)));
    check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check({tag, "_idle_after"}, 64'({busy[id], done[id]}), 64'd0);
    valid_en[id] = 1'b0;
  endtask

  logic [W-1:0] lfsr;
  logic [W-1:0] ea, eb;
  int           ndup;
  int           ndone;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; valid_en[i] = 1'b0; flush[i] = 1'b0;
      src_wr[i] = 0; m_cnt[i] = 0; m_rej[i] = 0; m_seen[i] = '0;
    end
    m_max[0] = 15; m_uniq[0] = 1;
    m_max[1] = 9;  m_uniq[1] = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check("reset_outputs", 64'({rnd_ready[i], busy[i], done[i], wr_en[i], wr_addr[i], wr_data[i],
                                  array_flat[i], reject_count[i]}), 64'd0);
    rst = 1'b0;

    begin_fill(0);
    supply(0, 9); supply(0, 3); supply(0, 6); supply(0, 13); supply(0, 10); supply(0, 5);
    run_fill(0, 0, 0, "basic");
    check("basic_flat_literal", 64'(array_flat[0]), 64'h5AD639);

    begin_fill(1);
    supply(1, 0); supply(1, 12); supply(1, 4); supply(1, 5); supply(1, 6);
    supply(1, 7); supply(1, 8); supply(1, 9);
    run_fill(1, 0, 0, "range");
    check("range_entry0", 64'(array_flat[1][3:0]), 64'd4);
    check("range_rejects", 64'(reject_count[1]), 64'd2);

    begin_fill(0);
    supply(0, 3); supply(0, 3); supply(0, 7); supply(0, 1); supply(0, 2); supply(0, 4); supply(0, 5);
    run_fill(0, 0, 0, "dup_unique");
    check("dup_unique_entry1", 64'(array_flat[0][7:4]), 64'd7);
    check("dup_unique_rejects", 64'(reject_count[0]), 64'd1);

    begin_fill(1);
    supply(1, 3); supply(1, 3); supply(1, 1); supply(1, 2); supply(1, 4); supply(1, 5);
    run_fill(1, 0, 0, "dup_nonunique");
    check("dup_nonunique_entry1", 64'(array_flat[1][7:4]), 64'd3);

    begin_fill(0);
    supply(0, 2); supply(0, 4); supply(0, 6); supply(0, 8); supply(0, 10); supply(0, 12);
    run_fill(0, 3, 0, "backpressure");

    begin_fill(0);
    supply(0, 15); supply(0, 14); supply(0, 13); supply(0, 12); supply(0, 11); supply(0, 1);
    run_fill(0, 0, 5, "start_busy");

    // Reset after three writes: no done pulse, everything back to zero.
    begin_fill(0);
    for (int v = 1; v <= N; v++) supply(0, v);
    valid_en[0] = 1'b1;
    @(negedge clk) start[0] = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk) start[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", 64'({rnd_ready[0], busy[0], done[0], wr_en[0], wr_addr[0], wr_data[0],
                                 array_flat[0], reject_count[0]}), 64'd0);
    check("midrst_writes_left", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    start[0] = 1'b1;
    @(negedge clk);
    check("rst_beats_start", 64'(busy[0]), 64'd0);
    start[0] = 1'b0;
    rst = 1'b0;
    valid_en[0] = 1'b0;
    ndone = 0;
    repeat (6) @(negedge clk) if (done[0] || busy[0]) ndone++;
    check("midrst_no_done", 64'(ndone), 64'd0);

    begin_fill(0);
    supply(0, 7); supply(0, 8); supply(0, 9); supply(0, 10); supply(0, 11); supply(0, 12);
    run_fill(0, 0, 0, "after_rst");

    // x^4+x^3+1 LFSR seeded 1001 as the source.
    begin_fill(0);
    lfsr = 4'b1001;
    for (int k = 0; k < N; k++) begin
      supply(0, int'(lfsr));
      lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
    run_fill(0, 0, 0, "lfsr");
    ndup = 0;
    for (int a = 0; a < N; a++) begin
      ea = array_flat[0][a*W +: W];
      if (ea == '0) ndup++;
      for (int b = a + 1; b < N; b++) begin
        eb = array_flat[0][b*W +: W];
        if (ea == eb) ndup++;
      end
    end
    check("lfsr_distinct_nonzero", 64'(ndup), 64'd0);
    check("lfsr_rejects", 64'(reject_count[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
